// File: rtl/sdi_pkg.sv
// Shared SDI definitions: TRS word constants, detector state encoding and
// the XYZ protection-bit function used by the TRS decoder.
package sdi_pkg;

  localparam logic [9:0] TRS_FF = 10'h3FF;
  localparam logic [9:0] TRS_00 = 10'h000;

  localparam int DELAY_DEPTH = 4;

  typedef enum logic [1:0] {
    SCAN,
    GOT_FF,
    GOT_Z1,
    GOT_Z2
  } trs_state_e;

  // Protection bits {P3, P2, P1, P0} expected for a given F/V/H triple.
  function automatic logic [3:0] xyz_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/sdi_word_delay.sv
// Enable-gated word delay line where each stage carries a TRS tag; a tag-set
// marks the incoming word and every older word still held in the line.
module sdi_word_delay #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_tag_set,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_tag
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stages are reset even though they form a storage array,
      // because the last stage drives vid_data straight to the output.
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_tag <= '0;
    end else if (i_en) begin
      r_data[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_data[i] <= r_data[i-1];
      // After this shift the line holds the new word plus the DEPTH-1 words
      // before it, which is exactly the set a tag-set has to mark.
      if (i_tag_set) r_tag <= '1;
      else           r_tag <= {r_tag[DEPTH-2:0], 1'b0};
    end
  end

  assign o_data = r_data[DEPTH-1];
  assign o_tag  = r_tag[DEPTH-1];

endmodule

// File: rtl/sdi_trs_decoder.sv
// SDI TRS decoder: finds 3FF 000 000 XYZ, checks XYZ protection, tracks
// field/vblank, line and sample counts, line lock, and flags active video.
module sdi_trs_decoder
  import sdi_pkg::*;
#(
  parameter int WORD_WIDTH = 10,
  parameter int LINE_W     = 11,
  parameter int SAMPLE_W   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic [WORD_WIDTH-1:0] vid_data,
  output logic                  vid_valid,
  output logic                  eav,
  output logic                  sav,
  output logic                  field,
  output logic                  vblank,
  output logic [LINE_W-1:0]     line_cnt,
  output logic [SAMPLE_W-1:0]   sample_cnt,
  output logic                  trs_err,
  output logic                  locked
);

  trs_state_e r_state;
  trs_state_e w_state_nxt;

  logic [9:0]          w_word10;
  logic                w_is_ff;
  logic                w_is_00;
  logic                w_f;
  logic                w_v;
  logic                w_h;
  logic                w_at_xyz;
  logic                w_xyz_ok;
  logic                w_eav_hit;
  logic                w_sav_hit;
  logic                w_err_hit;
  logic [SAMPLE_W-1:0] w_sample_inc;
  logic [LINE_W-1:0]   w_line_inc;

  logic                r_eav;
  logic                r_sav;
  logic                r_err;
  logic                r_field;
  logic                r_vblank;
  logic [LINE_W-1:0]   r_line;
  logic [SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W-1:0] r_line_len;
  logic                r_locked;
  logic                r_active;

  logic [WORD_WIDTH:0] w_dly_data;
  logic                w_dly_tag;

  // The 10-bit SDI code sits in the top bits; wider words carry extra LSBs.
  assign w_word10 = word_in[WORD_WIDTH-1 -: 10];
  assign w_is_ff  = (w_word10 == TRS_FF);
  assign w_is_00  = (w_word10 == TRS_00);
  assign {w_f, w_v, w_h} = w_word10[8:6];

  assign w_at_xyz  = word_valid && (r_state == GOT_Z2);
  assign w_xyz_ok  = w_word10[9] && (w_word10[5:2] == xyz_prot(w_f, w_v, w_h));
  assign w_eav_hit = w_at_xyz &&  w_xyz_ok &&  w_h;
  assign w_sav_hit = w_at_xyz &&  w_xyz_ok && !w_h;
  assign w_err_hit = w_at_xyz && !w_xyz_ok;

  assign w_sample_inc = (&r_sample) ? r_sample : r_sample + SAMPLE_W'(1);
  assign w_line_inc   = (&r_line)   ? r_line   : r_line + LINE_W'(1);

  always_comb begin
    // NOTE: a default is assigned before any branch so every path drives
    // w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    if (word_valid) begin
      if (w_is_ff) begin
        w_state_nxt = GOT_FF;
      end else begin
        case (r_state)
          GOT_FF:  w_state_nxt = w_is_00 ? GOT_Z1 : SCAN;
          GOT_Z1:  w_state_nxt = w_is_00 ? GOT_Z2 : SCAN;
          default: w_state_nxt = SCAN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SCAN;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eav      <= 1'b0;
      r_sav      <= 1'b0;
      r_err      <= 1'b0;
      r_field    <= 1'b0;
      r_vblank   <= 1'b1;
      r_line     <= '0;
      r_sample   <= '0;
      r_line_len <= '0;
      r_locked   <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the line-length compare
      // below sees the previous capture, not the one written this edge.
      r_eav <= w_eav_hit;
      r_sav <= w_sav_hit;
      r_err <= w_err_hit;
      if (word_valid) begin
        r_sample <= w_eav_hit ? '0 : w_sample_inc;
        if (w_eav_hit || w_sav_hit) begin
          r_field  <= w_f;
          r_vblank <= w_v;
        end
        if (w_eav_hit) begin
          r_line     <= (r_field && !w_f) ? LINE_W'(1) : w_line_inc;
          r_line_len <= w_sample_inc;
          r_locked   <= (w_sample_inc == r_line_len);
          r_active   <= 1'b0;
        end else if (w_sav_hit) begin
          r_active <= !w_v;
        end else if (w_err_hit) begin
          r_locked <= 1'b0;
        end
      end
    end
  end

  // Each word travels with the active-region flag in force when it arrived.
  sdi_word_delay #(
    .WIDTH (WORD_WIDTH + 1),
    .DEPTH (DELAY_DEPTH)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (word_valid),
    .i_tag_set (w_eav_hit || w_sav_hit),
    .i_data    ({r_active, word_in}),
    .o_data    (w_dly_data),
    .o_tag     (w_dly_tag)
  );

  assign vid_data   = w_dly_data[WORD_WIDTH-1:0];
  assign vid_valid  = word_valid && w_dly_data[WORD_WIDTH] && !w_dly_tag;
  assign eav        = r_eav;
  assign sav        = r_sav;
  assign trs_err    = r_err;
  assign field      = r_field;
  assign vblank     = r_vblank;
  assign line_cnt   = r_line;
  assign sample_cnt = r_sample;
  assign locked     = r_locked;

endmodule
